// File: rtl/lm32_dtlb_walker.sv
// -----------------------------------------------------------------------------
// lm32_dtlb_walker
//
// Hardware page-table walker for the LM32 data TLB. On a DTLB miss it walks a
// two-level table of 4 KB pages over a Wishbone classic master port. The walk
// ends in one of two ways:
//   - a one-cycle refill pulse for the DTLB (upd_valid), or
//   - a one-cycle fault pulse (fault) carrying a reason code.
//
// Ports
//   clk_i, rst_i         clock; synchronous active-high reset
//   walk_req, walk_vaddr miss request and faulting virtual address
//   ptbr                 page-table base (bits 31:12 used)
//   abort                cancel an in-progress walk
//   busy                 high whenever the walker is not idle
//   d_adr_o .. d_err_i   Wishbone classic read master (word aligned, sel = F)
//   upd_valid/vaddr/paddr  refill entry (paddr bit 0 = CSR write strobe)
//   fault/fault_code/fault_vaddr  failure report
//                        fault_code: 01 L1 invalid, 10 L2 invalid, 11 bus err/timeout
//
// Timing with a zero-wait slave: request sampled in cycle 0, L1 strobe in
// cycle 1, one idle bus cycle, L2 strobe in cycle 3, one idle bus cycle,
// and the refill pulse in cycle 5. The pulse outputs are registered, so
// busy is already low in the cycle that carries the pulse.
// -----------------------------------------------------------------------------
module lm32_dtlb_walker #(
  parameter int unsigned timeout_cycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        walk_req,
  input  logic [31:0] walk_vaddr,
  input  logic [31:0] ptbr,
  input  logic        abort,
  output logic        busy,
  output logic [31:0] d_adr_o,
  output logic        d_cyc_o,
  output logic        d_stb_o,
  output logic        d_we_o,
  output logic [3:0]  d_sel_o,
  input  logic [31:0] d_dat_i,
  input  logic        d_ack_i,
  input  logic        d_err_i,
  output logic        upd_valid,
  output logic [31:0] upd_vaddr,
  output logic [31:0] upd_paddr,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_vaddr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_L1    = 3'd1;
  localparam logic [2:0] ST_L2    = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  localparam logic [1:0] CODE_L1_INVALID = 2'b01;
  localparam logic [1:0] CODE_L2_INVALID = 2'b10;
  localparam logic [1:0] CODE_BUS        = 2'b11;

  // Last wait-counter value before the phase is declared dead.
  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  logic [2:0]  r_state;
  logic        r_stb;
  logic [31:0] r_adr;
  logic [31:0] r_vaddr;
  logic [19:0] r_l2base;
  logic [19:0] r_pfn;
  logic [15:0] r_tmo;
  logic [1:0]  r_pend_code;
  logic        r_upd_valid;
  logic [31:0] r_upd_vaddr;
  logic [31:0] r_upd_paddr;
  logic        r_fault;
  logic [1:0]  r_fault_code;
  logic [31:0] r_fault_vaddr;

  logic w_ack;
  logic w_err;
  logic w_term;
  logic w_expire;
  logic w_unused_bits;

  // Terminations only count while a phase is outstanding; a stray ack in the
  // inter-level gap or after reset is ignored.
  assign w_ack    = r_stb & d_ack_i;
  assign w_err    = r_stb & d_err_i;
  assign w_term   = w_ack | w_err;
  assign w_expire = r_stb & ~w_term & (r_tmo == TMO_LAST);

  // Offset bits of the base register and the PTE flag bits other than valid
  // carry no meaning for the walk.
  assign w_unused_bits = ^{ptbr[11:0], d_dat_i[11:1]};

  always_ff @(posedge clk_i) begin
    // NOTE: every register here uses <= so all state advances together from
    // values sampled at the same edge; = would leak updates between lines.
    if (rst_i) begin
      // NOTE: data registers are reset too, not just control, because the
      // address and report outputs must read as zero after reset.
      r_state       <= ST_IDLE;
      r_stb         <= 1'b0;
      r_adr         <= '0;
      r_vaddr       <= '0;
      r_l2base      <= '0;
      r_pfn         <= '0;
      r_tmo         <= '0;
      r_pend_code   <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_vaddr   <= '0;
      r_upd_paddr   <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= '0;
      r_fault_vaddr <= '0;
    end else begin
      r_upd_valid <= 1'b0;
      r_fault     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (walk_req) begin
            r_vaddr <= walk_vaddr;
            r_adr   <= {ptbr[31:12], walk_vaddr[31:22], 2'b00};
            r_stb   <= 1'b1;
            r_tmo   <= '0;
            r_state <= ST_L1;
          end
        end

        ST_L1, ST_L2: begin
          if (!r_stb) begin
            // Inter-level gap: the bus has been idle for one cycle, so the
            // L2 phase may start now unless the walk was cancelled.
            if (abort) begin
              r_state <= ST_IDLE;
            end else begin
              r_adr <= {r_l2base, r_vaddr[21:12], 2'b00};
              r_stb <= 1'b1;
              r_tmo <= '0;
            end
          end else if (abort) begin
            // The slave owns the outstanding phase; keep strobing until it
            // terminates, but never report anything for this walk.
            if (w_term || w_expire) begin
              r_stb   <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tmo   <= r_tmo + 16'd1;
              r_state <= ST_DRAIN;
            end
          end else if (w_err || w_expire) begin
            r_stb       <= 1'b0;
            r_pend_code <= CODE_BUS;
            r_state     <= ST_FAIL;
          end else if (w_ack) begin
            r_stb <= 1'b0;
            if (!d_dat_i[0]) begin
              r_pend_code <= (r_state == ST_L1) ? CODE_L1_INVALID : CODE_L2_INVALID;
              r_state     <= ST_FAIL;
            end else if (r_state == ST_L1) begin
              r_l2base <= d_dat_i[31:12];
              r_state  <= ST_L2;
            end else begin
              r_pfn   <= d_dat_i[31:12];
              r_state <= ST_DONE;
            end
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end

        ST_DRAIN: begin
          if (w_term || w_expire) begin
            r_stb   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end

        ST_DONE: begin
          // Report registers change only together with their pulse so they
          // hold the last result until the next one.
          r_upd_valid <= 1'b1;
          r_upd_vaddr <= {r_vaddr[31:12], 12'h000};
          r_upd_paddr <= {r_pfn, 11'h000, 1'b1};
          r_state     <= ST_IDLE;
        end

        ST_FAIL: begin
          r_fault       <= 1'b1;
          r_fault_code  <= r_pend_code;
          r_fault_vaddr <= r_vaddr;
          r_state       <= ST_IDLE;
        end

        default: begin
          r_stb   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign d_adr_o     = r_adr;
  assign d_cyc_o     = r_stb;
  assign d_stb_o     = r_stb;
  assign d_we_o      = 1'b0;
  assign d_sel_o     = 4'hF;
  assign upd_valid   = r_upd_valid;
  assign upd_vaddr   = r_upd_vaddr;
  assign upd_paddr   = r_upd_paddr;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign fault_vaddr = r_fault_vaddr;

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// -----------------------------------------------------------------------------
// tb_lm32_dtlb_walker
//
// Bench for lm32_dtlb_walker. The bench acts as the Wishbone slave, serving
// page-table entries from a sparse memory with a chosen number of wait states
// (or none at all) per level. A reference model derives, from the walk rules
// alone, which addresses are fetched, how long each strobe lasts, which pulse
// appears in which cycle and what it carries.
// -----------------------------------------------------------------------------
module tb_lm32_dtlb_walker;

  localparam int T     = 4;   // timeout used for the DUT instance
  localparam int WIN   = 30;  // cycles observed per walk
  localparam int NEVER = 99;  // wait count meaning "slave never answers"

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        walk_req;
  logic [31:0] walk_vaddr;
  logic [31:0] ptbr;
  logic        abort;
  logic        busy;
  logic [31:0] d_adr_o;
  logic        d_cyc_o;
  logic        d_stb_o;
  logic        d_we_o;
  logic [3:0]  d_sel_o;
  logic [31:0] d_dat_i;
  logic        d_ack_i;
  logic        d_err_i;
  logic        upd_valid;
  logic [31:0] upd_vaddr;
  logic [31:0] upd_paddr;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_vaddr;

  lm32_dtlb_walker #(.timeout_cycles(T)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .walk_req    (walk_req),
    .walk_vaddr  (walk_vaddr),
    .ptbr        (ptbr),
    .abort       (abort),
    .busy        (busy),
    .d_adr_o     (d_adr_o),
    .d_cyc_o     (d_cyc_o),
    .d_stb_o     (d_stb_o),
    .d_we_o      (d_we_o),
    .d_sel_o     (d_sel_o),
    .d_dat_i     (d_dat_i),
    .d_ack_i     (d_ack_i),
    .d_err_i     (d_err_i),
    .upd_valid   (upd_valid),
    .upd_vaddr   (upd_vaddr),
    .upd_paddr   (upd_paddr),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_vaddr (fault_vaddr)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Page-table memory seen by the slave.
  logic [31:0] pt_mem [logic [31:0]];

  // Per-walk slave behaviour and abort timing.
  int w [2];
  bit e [2];
  int abort_cyc;

  // Observations of one walk.
  int          n_acc, upd_cnt, flt_cnt, both_cnt, proto_bad;
  int          upd_cyc, flt_cyc, busy_low;
  int          obs_len [4];
  logic [31:0] obs_adr [2];
  logic [31:0] obs_upd_v, obs_upd_p, obs_flt_v;
  logic [1:0]  obs_code;

  // Reference expectations of one walk (kind: 0 refill, 1..3 fault code, 4 none).
  int          exp_n_acc, exp_kind, exp_pulse, exp_busy_low;
  int          exp_len [2];
  logic [31:0] exp_adr [2];
  logic [31:0] exp_upd_v, exp_upd_p;

  // What the report outputs must be holding from the latest pulses.
  logic [31:0] last_upd_v = '0, last_upd_p = '0, last_flt_v = '0;
  logic [1:0]  last_code = '0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (pt_mem.exists(a)) return pt_mem[a];
    return 32'h0000_0FF0;  // unmapped: reads as an invalid entry
  endfunction

  // Reference walk: table arithmetic plus cycle bookkeeping per bus phase.
  task automatic model(input logic [31:0] vaddr, input logic [31:0] pt);
    logic [31:0] adr, pte;
    int start, len, end_c;
    bit tmo;
    exp_n_acc = 0; exp_kind = 4; exp_pulse = -1; exp_busy_low = -1;
    exp_len = '{0, 0}; exp_adr = '{32'h0, 32'h0};
    exp_upd_v = '0; exp_upd_p = '0;
    adr   = (pt & 32'hFFFF_F000) + (vaddr >> 22) * 4;
    start = 1;
    for (int lvl = 0; lvl < 2; lvl++) begin
      exp_n_acc    = lvl + 1;
      exp_adr[lvl] = adr;
      tmo          = (w[lvl] >= T);
      len          = tmo ? T : w[lvl] + 1;
      exp_len[lvl] = len;
      end_c        = start + len - 1;
      pte          = mem_rd(adr);
      if (abort_cyc >= start && abort_cyc <= end_c) begin
        exp_busy_low = end_c + 1;
        return;
      end
      if (tmo || e[lvl]) begin
        exp_kind = 3; exp_pulse = end_c + 2; exp_busy_low = exp_pulse;
        return;
      end
      if (!pte[0]) begin
        exp_kind = lvl + 1; exp_pulse = end_c + 2; exp_busy_low = exp_pulse;
        return;
      end
      if (lvl == 0) begin
        adr   = (pte & 32'hFFFF_F000) + ((vaddr >> 12) & 32'h3FF) * 4;
        start = end_c + 2;
      end else begin
        exp_kind     = 0;
        exp_pulse    = end_c + 2;
        exp_busy_low = exp_pulse;
        exp_upd_v    = vaddr & 32'hFFFF_F000;
        exp_upd_p    = (pte & 32'hFFFF_F000) | 32'h1;
      end
    end
  endtask

  // Issue one walk request and play the slave for WIN cycles.
  task automatic run_walk(input logic [31:0] vaddr, input logic [31:0] pt);
    int  wcnt, lvl;
    bit  prev_stb;
    n_acc = 0; upd_cnt = 0; flt_cnt = 0; both_cnt = 0; proto_bad = 0;
    upd_cyc = -1; flt_cyc = -1; busy_low = -1;
    obs_len = '{0, 0, 0, 0}; obs_adr = '{32'h0, 32'h0};
    obs_upd_v = '0; obs_upd_p = '0; obs_flt_v = '0; obs_code = '0;
    walk_req = 1'b1; walk_vaddr = vaddr; ptbr = pt; abort = (abort_cyc == 0);
    tick();
    walk_req = 1'b0; walk_vaddr = $urandom; ptbr = $urandom;
    prev_stb = 1'b0; wcnt = 0;
    for (int c = 1; c <= WIN; c++) begin
      d_ack_i = 1'b0; d_err_i = 1'b0; d_dat_i = $urandom;
      abort = (c == abort_cyc);
      if (d_stb_o) begin
        if (!prev_stb) begin
          if (n_acc < 2) obs_adr[n_acc] = d_adr_o;
          n_acc++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
        if (n_acc <= 4) obs_len[n_acc-1]++;
        lvl = (n_acc > 1) ? 1 : 0;
        if (wcnt == w[lvl]) begin
          if (e[lvl]) d_err_i = 1'b1;
          else begin
            d_ack_i = 1'b1;
            d_dat_i = mem_rd(d_adr_o);
          end
        end
      end
      prev_stb = d_stb_o;
      if (d_cyc_o !== d_stb_o || d_we_o !== 1'b0 || d_sel_o !== 4'hF) proto_bad++;
      if (upd_valid && fault) both_cnt++;
      if (upd_valid) begin
        upd_cnt++;
        if (upd_cnt == 1) begin upd_cyc = c; obs_upd_v = upd_vaddr; obs_upd_p = upd_paddr; end
      end
      if (fault) begin
        flt_cnt++;
        if (flt_cnt == 1) begin flt_cyc = c; obs_code = fault_code; obs_flt_v = fault_vaddr; end
      end
      if (!busy && busy_low < 0) busy_low = c;
      tick();
    end
    d_ack_i = 1'b0; d_err_i = 1'b0; abort = 1'b0;
  endtask

  task automatic walk_and_check(input string tag, input logic [31:0] vaddr, input logic [31:0] pt);
    model(vaddr, pt);
    run_walk(vaddr, pt);
    if (exp_kind == 0) begin
      last_upd_v = exp_upd_v; last_upd_p = exp_upd_p;
    end else if (exp_kind != 4) begin
      last_code = 2'(exp_kind); last_flt_v = vaddr;
    end
    check({tag, ":accesses"}, 32'(n_acc), 32'(exp_n_acc));
    for (int i = 0; i < exp_n_acc; i++) begin
      check($sformatf("%s:adr%0d", tag, i), obs_adr[i], exp_adr[i]);
      check($sformatf("%s:stb_len%0d", tag, i), 32'(obs_len[i]), 32'(exp_len[i]));
    end
    check({tag, ":upd_count"}, 32'(upd_cnt), (exp_kind == 0) ? 32'd1 : 32'd0);
    check({tag, ":fault_count"}, 32'(flt_cnt), (exp_kind >= 1 && exp_kind <= 3) ? 32'd1 : 32'd0);
    check({tag, ":both_high"}, 32'(both_cnt), 32'd0);
    check({tag, ":bus_static"}, 32'(proto_bad), 32'd0);
    check({tag, ":busy_low_cyc"}, 32'(busy_low), 32'(exp_busy_low));
    if (exp_kind == 0) begin
      check({tag, ":upd_cyc"}, 32'(upd_cyc), 32'(exp_pulse));
      check({tag, ":upd_vaddr"}, obs_upd_v, exp_upd_v);
      check({tag, ":upd_paddr"}, obs_upd_p, exp_upd_p);
    end else if (exp_kind != 4) begin
      check({tag, ":fault_cyc"}, 32'(flt_cyc), 32'(exp_pulse));
      check({tag, ":fault_code"}, 32'(obs_code), 32'(exp_kind));
      check({tag, ":fault_vaddr"}, obs_flt_v, vaddr);
    end
    check({tag, ":hold_upd_vaddr"}, upd_vaddr, last_upd_v);
    check({tag, ":hold_upd_paddr"}, upd_paddr, last_upd_p);
    check({tag, ":hold_fault_code"}, 32'(fault_code), 32'(last_code));
    check({tag, ":hold_fault_vaddr"}, fault_vaddr, last_flt_v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":cyc"}, 32'(d_cyc_o), 32'd0);
    check({tag, ":stb"}, 32'(d_stb_o), 32'd0);
    check({tag, ":adr"}, d_adr_o, 32'h0);
    check({tag, ":upd_valid"}, 32'(upd_valid), 32'd0);
    check({tag, ":fault"}, 32'(fault), 32'd0);
    check({tag, ":upd_vaddr"}, upd_vaddr, 32'h0);
    check({tag, ":upd_paddr"}, upd_paddr, 32'h0);
    check({tag, ":fault_vaddr"}, fault_vaddr, 32'h0);
    check({tag, ":fault_code"}, 32'(fault_code), 32'd0);
    check({tag, ":we"}, 32'(d_we_o), 32'd0);
    check({tag, ":sel"}, 32'(d_sel_o), 32'hF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] va, pt, pte1, pte2, l1a, l2a;
    int len0, len1;
    rst_i = 1'b1; walk_req = 1'b0; walk_vaddr = '0; ptbr = '0; abort = 1'b0;
    d_dat_i = '0; d_ack_i = 1'b0; d_err_i = 1'b0;
    abort_cyc = -1; w = '{0, 0}; e = '{0, 0};

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();

    // Happy path, zero wait states
    pt_mem.delete();
    pt_mem[32'h0010_0120] = 32'h0020_0001;
    pt_mem[32'h0020_0D14] = 32'h0ABC_D001;
    walk_and_check("happy", 32'h1234_5678, 32'h0010_0000);
    check("happy:l1_adr_const", obs_adr[0], 32'h0010_0120);
    check("happy:l2_adr_const", obs_adr[1], 32'h0020_0D14);
    check("happy:upd_vaddr_const", obs_upd_v, 32'h1234_5000);
    check("happy:upd_paddr_const", obs_upd_p, 32'h0ABC_D001);
    check("happy:upd_cycle_const", 32'(upd_cyc), 32'd5);

    // L1 entry invalid
    pt_mem[32'h0010_0120] = 32'h0020_0000;
    walk_and_check("l1inv", 32'h1234_5678, 32'h0010_0000);
    check("l1inv:accesses_const", 32'(n_acc), 32'd1);
    check("l1inv:code_const", 32'(obs_code), 32'd1);
    check("l1inv:vaddr_const", obs_flt_v, 32'h1234_5678);

    // Bus error on L2 after 3 wait states
    pt_mem[32'h0010_0120] = 32'h0020_0001;
    w = '{0, 3}; e = '{0, 1};
    walk_and_check("l2err", 32'h1234_5678, 32'h0010_0000);
    check("l2err:stb_len_const", 32'(obs_len[1]), 32'd4);
    check("l2err:code_const", 32'(obs_code), 32'd3);
    check("l2err:busy_low_const", 32'(busy_low), 32'd8);

    // Slave never answers at L1
    w = '{NEVER, 0}; e = '{0, 0};
    walk_and_check("timeout", 32'h1234_5678, 32'h0010_0000);
    check("timeout:stb_len_const", 32'(obs_len[0]), 32'd4);
    check("timeout:code_const", 32'(obs_code), 32'd3);

    // Abort in the first L2 cycle, slave acks 2 cycles later
    w = '{0, 2}; abort_cyc = 3;
    walk_and_check("abort", 32'h1234_5678, 32'h0010_0000);
    check("abort:stb_len_const", 32'(obs_len[1]), 32'd3);
    check("abort:pulses_const", 32'(upd_cnt + flt_cnt), 32'd0);
    w = '{0, 0}; abort_cyc = -1;
    walk_and_check("after_abort", 32'h1234_5678, 32'h0010_0000);
    check("after_abort:upd_paddr_const", obs_upd_p, 32'h0ABC_D001);

    // Reset during the L1 wait, then a stray ack
    walk_req = 1'b1; walk_vaddr = 32'h1234_5678; ptbr = 32'h0010_0000;
    tick();
    walk_req = 1'b0;
    check("rstmid:stb_before", 32'(d_stb_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    check_reset_outputs("rstmid");
    rst_i = 1'b0; d_ack_i = 1'b1; d_dat_i = 32'h0020_0001;
    upd_cnt = 0; flt_cnt = 0; proto_bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      d_ack_i = 1'b0;
      if (upd_valid) upd_cnt++;
      if (fault) flt_cnt++;
      if (busy || d_stb_o) proto_bad++;
    end
    check("rstmid:stray_pulses", 32'(upd_cnt + flt_cnt), 32'd0);
    check("rstmid:stray_activity", 32'(proto_bad), 32'd0);
    last_upd_v = '0; last_upd_p = '0; last_flt_v = '0; last_code = '0;

    // Randomized walks
    for (int n = 0; n < 40; n++) begin
      va = $urandom;
      pt = $urandom & 32'h7FFF_FFFF;
      pt_mem.delete();
      l1a  = (pt & 32'hFFFF_F000) + (va >> 22) * 4;
      pte1 = {1'b1, 19'($urandom), 12'($urandom)};
      pte1[0] = ($urandom_range(0, 9) != 0);
      pt_mem[l1a] = pte1;
      l2a  = (pte1 & 32'hFFFF_F000) + ((va >> 12) & 32'h3FF) * 4;
      pte2 = $urandom;
      pte2[0] = ($urandom_range(0, 9) != 0);
      pt_mem[l2a] = pte2;
      w[0] = $urandom_range(0, 5);
      w[1] = $urandom_range(0, 5);
      e[0] = ($urandom_range(0, 7) == 0);
      e[1] = ($urandom_range(0, 7) == 0);
      len0 = (w[0] >= T) ? T : w[0] + 1;
      len1 = (w[1] >= T) ? T : w[1] + 1;
      abort_cyc = -1;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) abort_cyc = 1 + $urandom_range(0, len0 - 1);
        else abort_cyc = len0 + 2 + $urandom_range(0, len1 - 1);
      end
      walk_and_check($sformatf("rand%0d", n), va, pt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm32_dtlb_walker.md
LM32_DTLB_WALKER -- requirements
Module: lm32_dtlb_walker

Interface
REQ-001 Parameter timeout_cycles, default 256: bus cycles to wait for ack/err before a walk is declared failed; legal range 2..65535.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 walk_req  input  1  DTLB miss indication; a walk starts when sampled high in IDLE.
REQ-005 walk_vaddr  input  32  faulting virtual address; sampled with walk_req.
REQ-006 ptbr  input  32  page-table base; bits 31:12 used, 11:0 ignored.
REQ-007 abort  input  1  cancels an in-progress walk (TLB flush/mode switch).
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 d_adr_o  output  32  Wishbone address, word aligned.
REQ-010 d_cyc_o, d_stb_o  output  1 each  Wishbone classic cycle/strobe, always equal.
REQ-011 d_we_o  output  1  constant 0; d_sel_o  output  4  constant 4'hF.
REQ-012 d_dat_i  input  32  read data; d_ack_i, d_err_i  input  1 each  termination.
REQ-013 upd_valid  output  1  one-cycle pulse: refill entry ready for the DTLB.
REQ-014 upd_vaddr  output  32  {vaddr[31:12], 12'h000}.
REQ-015 upd_paddr  output  32  {pfn[31:12], 11'h000, 1'b1}; bit 0 set as the CSR write strobe.
REQ-016 fault  output  1  one-cycle pulse: walk failed; fault_code  output  2  01 L1 invalid, 10 L2 invalid, 11 bus error/timeout; fault_vaddr  output  32  failing vaddr.

Function
REQ-017 Pages are 4 KB; two-level table; L1 index = vaddr[31:22], L2 index = vaddr[21:12]; PTE bit 0 = valid, PTE[31:12] = next-level base or PFN.
REQ-018 States: IDLE, L1, L2, DONE, FAIL, DRAIN.
REQ-019 IDLE: on walk_req high, latch walk_vaddr and ptbr, go to L1 next cycle; walk_req ignored in all other states.
REQ-020 L1: assert cyc/stb with d_adr_o = {ptbr[31:12], vaddr[31:22], 2'b00}.
REQ-021 L1 termination: ack with d_dat_i[0]=1 -> latch d_dat_i[31:12] as the L2 base, go to L2; ack with d_dat_i[0]=0 -> FAIL code 01; err -> FAIL code 11.
REQ-022 L2: d_adr_o = {l2base[31:12], vaddr[21:12], 2'b00}; ack valid -> latch PFN, go to DONE; ack invalid -> FAIL code 10; err -> FAIL code 11.
REQ-023 cyc/stb SHALL deassert in the cycle after ack/err is sampled; there are no back-to-back bus phases across levels without one deasserted cycle.
REQ-024 Timeout counter: clears on entry to L1/L2, increments each waiting cycle; reaching timeout_cycles without ack/err -> drop cyc/stb, go to FAIL code 11.
REQ-025 DONE: upd_valid=1 for exactly one cycle, then IDLE; FAIL: fault=1 for exactly one cycle, then IDLE.
REQ-026 upd_vaddr, upd_paddr, fault_code and fault_vaddr SHALL hold their values from the last pulse until the next one.
REQ-027 Minimum latency (zero-wait-state slave): walk_req sampled at cycle 0 -> L1 stb at cycle 1, L2 stb at cycle 3, upd_valid at cycle 5.
REQ-028 abort in IDLE/DONE/FAIL: no effect. abort during L1/L2 with a bus phase outstanding -> DRAIN; stb stays high until ack/err/timeout, data is discarded, then IDLE with no pulse.
REQ-029 abort coincident with ack/err: walk is cancelled, no upd_valid or fault pulse, next state IDLE.
REQ-030 upd_valid and fault SHALL never be high in the same cycle.

Reset
REQ-031 rst_i high at any clock edge, including mid bus cycle -> state IDLE; cyc/stb/busy/upd_valid/fault = 0; d_adr_o, upd_vaddr, upd_paddr, fault_vaddr = 0; fault_code = 00; timeout counter = 0.
REQ-032 A Wishbone cycle dropped by reset is not resumed; a late ack after reset SHALL be ignored.

Verification
REQ-033 Happy path: ptbr=0x00100000, vaddr=0x12345678, L1 PTE 0x00200001, L2 PTE 0x0ABCD001, zero wait -> L1 adr 0x00100120, L2 adr 0x00200D14, upd_vaddr 0x12345000, upd_paddr 0x0ABCD001, upd_valid at cycle 5.
REQ-034 L1 invalid: same vaddr, L1 PTE 0x00200000 -> no L2 access, fault=1 code 01, fault_vaddr 0x12345678.
REQ-035 Bus error on L2 with 3 wait states -> fault code 11, cyc deasserted the cycle after err, busy low the following cycle.
REQ-036 Timeout: timeout_cycles=4, slave never acks -> stb high exactly 4 cycles, fault code 11.
REQ-037 Abort at L2 with ack 2 cycles later -> stb held until ack, no pulse, IDLE; a fresh walk_req then completes normally.
REQ-038 Reset asserted during L1 wait -> all outputs at reset values next cycle; a subsequent stray ack produces no pulse.
